// File: rtl/pix_ro_pkg.sv
// Shared definitions for the pixel readout blocks: group geometry,
// encoder address layout and the frame decoder state encoding.
package pix_ro_pkg;

   localparam int N_PIX        = 8;
   localparam int ADDR_W       = 4;
   localparam int ADDR_HIT_BIT = 3;
   localparam logic [ADDR_W-1:0] EMPTY_CODE = 4'b0000;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_CLEAR = 2'd1;
   localparam state_t ST_SCAN  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/dec38_onehot.sv
// 3-to-8 decoder: turns an encoder pixel index plus hit flag into a
// one-hot pixel mask (all zero when no hit is flagged).
module dec38_onehot
   import pix_ro_pkg::*;
(
   input  logic [2:0]       idx,
   input  logic             hit,
   output logic [N_PIX-1:0] onehot
);

   // Single bit set at the reported pixel index when the hit flag is high.
   always_comb begin
      onehot = '0;
      if (hit) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/pix8_frame_decoder.sv
// Readout sequencer for one 8-pixel group: optionally clears the priority
// encoder, scans it one address per settle period, decodes each address
// into a hit frame and offers the frame to the column readout.
//
// Handshake: frame_valid is high only in DONE; frame, hit_cnt, dup_err and
// ovf_err are stable while it is high. A transfer happens on a rising edge
// with frame_valid && frame_ready; frame_valid falls on that edge. The
// frame contents stay on the outputs until the next accepted start.
module pix8_frame_decoder
   import pix_ro_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int CLR_CYC    = 2,
   parameter int MAX_STEPS  = 9
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clear_first,
   input  logic              abort,
   input  logic [ADDR_W-1:0] enc_addr,
   output logic              enc_read,
   output logic              enc_clear,
   output logic [N_PIX-1:0]  frame,
   output logic [3:0]        hit_cnt,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic              dup_err,
   output logic              ovf_err,
   output logic              busy
);

   state_t            state, state_nxt;
   logic [3:0]        settle_cnt;
   logic [3:0]        clr_cnt;
   logic [7:0]        step_cnt;
   logic [N_PIX-1:0]  addr_mask;
   logic              addr_hit;
   logic              sample;
   logic              last_step;
   logic              start_ok;

   assign addr_hit  = (enc_addr[ADDR_HIT_BIT] != EMPTY_CODE[ADDR_HIT_BIT]);
   assign sample    = (state == ST_SCAN) && (settle_cnt == 4'd0) && !abort;
   assign last_step = (step_cnt == 8'(MAX_STEPS - 1));
   assign start_ok  = (state == ST_IDLE) && start;

   dec38_onehot u_dec (
      .idx    (enc_addr[2:0]),
      .hit    (addr_hit),
      .onehot (addr_mask)
   );

   // State register; reset drops the encoder controls asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort outranks every other transition outside IDLE.
   always_comb begin
      state_nxt = state;
      if (state != ST_IDLE && abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_nxt = clear_first ? ST_CLEAR : ST_SCAN;
            ST_CLEAR: if (clr_cnt == 4'd0) state_nxt = ST_SCAN;
            ST_SCAN:  if (settle_cnt == 4'd0 && (!addr_hit || last_step))
                         state_nxt = ST_DONE;
            ST_DONE:  if (frame_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded purely from the registered state.
   always_comb begin
      enc_read    = (state == ST_SCAN);
      enc_clear   = (state == ST_CLEAR);
      frame_valid = (state == ST_DONE);
      busy        = (state != ST_IDLE);
   end

   // Counters and frame accumulation; a start zeroes the previous frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         clr_cnt    <= '0;
         step_cnt   <= '0;
         frame      <= '0;
         hit_cnt    <= '0;
         dup_err    <= 1'b0;
         ovf_err    <= 1'b0;
      end else if (start_ok) begin
         settle_cnt <= 4'(SETTLE_CYC - 1);
         clr_cnt    <= 4'(CLR_CYC - 1);
         step_cnt   <= '0;
         frame      <= '0;
         hit_cnt    <= '0;
         dup_err    <= 1'b0;
         ovf_err    <= 1'b0;
      end else if (!abort) begin
         if (state == ST_CLEAR && clr_cnt != 4'd0) clr_cnt <= clr_cnt - 4'd1;
         if (state == ST_SCAN && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
         if (sample) begin
            settle_cnt <= 4'(SETTLE_CYC - 1);
            step_cnt   <= step_cnt + 8'd1;
            if (addr_hit) begin
               frame <= frame | addr_mask;
               if ((frame & addr_mask) != '0) dup_err <= 1'b1;
               else if (hit_cnt != 4'(N_PIX)) hit_cnt <= hit_cnt + 4'd1;
               if (last_step) ovf_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pix8_frame_decoder.sv
// Bench for pix8_frame_decoder: directed vector table, randomized frames
// checked against a step-level reference model, and hand sequences for
// backpressure, start collisions, abort and asynchronous reset.
module tb_pix8_frame_decoder;
   import pix_ro_pkg::*;

   localparam int SETTLE = 2;
   localparam int CLR    = 2;
   localparam int MAXS   = 9;
   localparam int W      = 22;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       clear_first = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] enc_addr = 4'd0;
   logic       frame_ready = 1'b0;
   logic       enc_read, enc_clear, frame_valid, dup_err, ovf_err, busy;
   logic [7:0] frame;
   logic [3:0] hit_cnt;

   pix8_frame_decoder #(.SETTLE_CYC(SETTLE), .CLR_CYC(CLR), .MAX_STEPS(MAXS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear_first(clear_first),
      .abort(abort), .enc_addr(enc_addr), .enc_read(enc_read),
      .enc_clear(enc_clear), .frame(frame), .hit_cnt(hit_cnt),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .dup_err(dup_err), .ovf_err(ovf_err), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];

   typedef struct packed {
      logic        cf;
      logic [47:0] codes;
      logic [3:0]  n_codes;
      logic [7:0]  exp_frame;
      logic [3:0]  exp_cnt;
      logic        exp_dup;
      logic        exp_ovf;
      logic [7:0]  exp_lat;
   } vec_t;
   vec_t vecs[8];

   // measured by run_frame
   logic [7:0] m_frame;
   logic [3:0] m_cnt;
   logic       m_dup, m_ovf, m_timeout, m_overlap;
   int         m_lat, m_reads, m_clears, m_first_read;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [47:0] pk(input logic [3:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
      return {12'h000, c8, c7, c6, c5, c4, c3, c2, c1, c0};
   endfunction

   // Encoder script: code k, with the last code repeated forever.
   function automatic logic [3:0] code_at(input logic [47:0] c, input int n, input int k);
      int i;
      i = (k < n) ? k : n - 1;
      return c[4*i +: 4];
   endfunction

   // Reference model: walk the encoder script step by step.
   function automatic logic [W-1:0] model(input logic cf, input logic [47:0] codes, input int n);
      logic [7:0] fr = '0;
      int         cnt = 0;
      int         steps = 0;
      logic       dup = 1'b0;
      logic       ovf = 1'b0;
      logic [3:0] c;
      for (int k = 0; k < MAXS; k++) begin
         c = code_at(codes, n, k);
         steps = k + 1;
         if (!c[3]) break;
         if (fr[c[2:0]]) dup = 1'b1;
         else begin
            fr[c[2:0]] = 1'b1;
            cnt++;
         end
         if (steps == MAXS) ovf = 1'b1;
      end
      return {8'(steps * SETTLE + (cf ? CLR : 0)), dup, ovf, 4'(cnt), fr};
   endfunction

   // Driver: start a frame and play the encoder until frame_valid.
   task automatic run_frame(input logic cf, input logic [47:0] codes, input int n,
                            input int restart_at);
      int cyc = 0;
      m_clears = 0; m_reads = 0; m_first_read = 0; m_timeout = 0; m_overlap = 0;
      @(negedge clk);
      clear_first = cf;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      clear_first = 1'b0;
      while (1) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (frame_valid) break;
         if (cyc > 200) begin
            m_timeout = 1'b1;
            break;
         end
         if (enc_clear) m_clears++;
         if (enc_clear && enc_read) m_overlap = 1'b1;
         if (enc_read) begin
            if (m_reads == 0) m_first_read = cyc;
            enc_addr = code_at(codes, n, m_reads / SETTLE);
            m_reads++;
         end else begin
            enc_addr = 4'($urandom_range(0, 15));
         end
         if (cyc == restart_at) begin
            start = 1'b1;
            clear_first = 1'b1;
         end
      end
      clear_first = 1'b0;
      m_lat = cyc - 1;
      m_frame = frame; m_cnt = hit_cnt; m_dup = dup_err; m_ovf = ovf_err;
   endtask

   task automatic check_frame(input string tag, input logic cf, input logic [W-1:0] e);
      chk({tag, " timeout"}, int'(m_timeout), 0);
      chk({tag, " frame"}, int'(m_frame), int'(e[7:0]));
      chk({tag, " hit_cnt"}, int'(m_cnt), int'(e[11:8]));
      chk({tag, " ovf_err"}, int'(m_ovf), int'(e[12]));
      chk({tag, " dup_err"}, int'(m_dup), int'(e[13]));
      chk({tag, " latency"}, m_lat, int'(e[21:14]));
      chk({tag, " enc_clear cycles"}, m_clears, cf ? CLR : 0);
      chk({tag, " enc_read cycles"}, m_reads, int'(e[21:14]) - (cf ? CLR : 0));
      chk({tag, " first read cycle"}, m_first_read, (cf ? CLR : 0) + 1);
      chk({tag, " clear/read overlap"}, int'(m_overlap), 0);
   endtask

   // Hold off the consumer, then accept (optionally with a colliding start).
   task automatic hold_and_accept(input string tag, input int hold, input logic with_start);
      logic stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!frame_valid || frame !== m_frame || hit_cnt !== m_cnt ||
             dup_err !== m_dup || ovf_err !== m_ovf || !busy) stable = 1'b0;
      end
      if (hold > 0) chk({tag, " held under backpressure"}, int'(stable), 1);
      @(negedge clk);
      frame_ready = 1'b1;
      start = with_start;
      clear_first = with_start;
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      start = 1'b0;
      clear_first = 1'b0;
      @(negedge clk);
      chk({tag, " valid after accept"}, int'(frame_valid), 0);
      chk({tag, " busy after accept"}, int'(busy), 0);
      chk({tag, " frame kept after accept"}, int'(frame), int'(m_frame));
   endtask

   initial begin
      logic [W-1:0] e;
      logic [47:0]  codes;
      logic         cf;
      int           n;
      logic         seen_valid;

      vecs[0] = '{1'b0, pk(0,0,0,0,0,0,0,0,0), 4'd1, 8'h00, 4'd0, 1'b0, 1'b0, 8'd2};
      vecs[1] = '{1'b0, pk(4'hE,4'hB,4'h8,0,0,0,0,0,0), 4'd4, 8'h49, 4'd3, 1'b0, 1'b0, 8'd8};
      vecs[2] = '{1'b1, pk(4'hA,0,0,0,0,0,0,0,0), 4'd2, 8'h04, 4'd1, 1'b0, 1'b0, 8'd6};
      vecs[3] = '{1'b1, pk(0,0,0,0,0,0,0,0,0), 4'd1, 8'h00, 4'd0, 1'b0, 1'b0, 8'd4};
      vecs[4] = '{1'b0, pk(4'hD,4'hD,0,0,0,0,0,0,0), 4'd3, 8'h20, 4'd1, 1'b1, 1'b0, 8'd6};
      vecs[5] = '{1'b0, pk(4'hF,0,0,0,0,0,0,0,0), 4'd1, 8'h80, 4'd1, 1'b1, 1'b1, 8'd18};
      vecs[6] = '{1'b0, pk(4'h8,4'h9,4'hA,4'hB,4'hC,4'hD,4'hE,4'hF,0), 4'd9,
                  8'hFF, 4'd8, 1'b0, 1'b0, 8'd18};
      vecs[7] = '{1'b0, pk(4'h8,4'h9,4'hA,4'hB,4'hC,4'hD,4'hE,4'hF,4'h8), 4'd9,
                  8'hFF, 4'd8, 1'b1, 1'b1, 8'd18};

      // reset values
      #12;
      chk("reset busy", int'(busy), 0);
      chk("reset outputs", int'({enc_read, enc_clear, frame_valid, dup_err, ovf_err,
                                 frame, hit_cnt}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].cf, vecs[i].codes, int'(vecs[i].n_codes), -1);
         check_frame($sformatf("vec%0d", i), vecs[i].cf,
                     {vecs[i].exp_lat, vecs[i].exp_dup, vecs[i].exp_ovf,
                      vecs[i].exp_cnt, vecs[i].exp_frame});
         hold_and_accept($sformatf("vec%0d", i), 10, (i == 2));
      end

      // start during SCAN is ignored
      run_frame(1'b0, pk(4'hE,4'hB,4'h8,0,0,0,0,0,0), 4, 3);
      check_frame("restart_ignored", 1'b0, {8'd8, 1'b0, 1'b0, 4'd3, 8'h49});
      hold_and_accept("restart_ignored", 0, 1'b0);

      // randomized frames against the model
      for (int r = 0; r < 40; r++) begin
         cf = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 9);
         codes = '0;
         for (int k = 0; k < n - 1; k++) codes[4*k +: 4] = {1'b1, 3'($urandom_range(0, 7))};
         if ($urandom_range(0, 9) == 0) codes[4*(n-1) +: 4] = {1'b1, 3'($urandom_range(0, 7))};
         else codes[4*(n-1) +: 4] = 4'($urandom_range(0, 7)) & 4'b0111;
         exp_q.push_back(model(cf, codes, n));
         run_frame(cf, codes, n, -1);
         e = exp_q.pop_front();
         check_frame($sformatf("rand%0d", r), cf, e);
         hold_and_accept($sformatf("rand%0d", r), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // abort mid-SCAN
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      enc_addr = 4'hC;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort scan busy", int'(busy), 0);
      chk("abort scan enc_read", int'(enc_read), 0);
      seen_valid = frame_valid;
      repeat (10) begin
         @(negedge clk);
         seen_valid = seen_valid | frame_valid;
      end
      chk("abort no frame_valid", int'(seen_valid), 0);

      // abort during CLEAR
      @(negedge clk);
      start = 1'b1;
      clear_first = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      clear_first = 1'b0;
      @(negedge clk);
      chk("clear phase enc_clear", int'(enc_clear), 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort clear enc_clear", int'(enc_clear), 0);
      chk("abort clear busy", int'(busy), 0);

      // asynchronous reset mid-SCAN
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      enc_addr = 4'hB;
      repeat (3) @(negedge clk);
      chk("pre-reset frame", int'(frame), 8'h08);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset busy", int'(busy), 0);
      chk("async reset outputs", int'({enc_read, enc_clear, frame_valid, dup_err, ovf_err,
                                        frame, hit_cnt}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // one clean frame after reset
      run_frame(1'b0, pk(4'h9,0,0,0,0,0,0,0,0), 2, -1);
      check_frame("post_reset", 1'b0, {8'd4, 1'b0, 1'b0, 4'd1, 8'h02});
      hold_and_accept("post_reset", 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule
